// File: rtl/turn_cursor_ctrl.sv
// Tic-tac-toe controller: button synchronisation, cursor movement, board
// bookkeeping, turn alternation with idle forfeit, and win/draw detection.
// posX/posY/contadorTurno feed the sprite-select mux downstream.
module turn_cursor_ctrl #(
    parameter int CELL_W      = 160,
    parameter int CELL_H      = 160,
    parameter int ORIGIN_X    = 80,
    parameter int ORIGIN_Y    = 0,
    parameter int TIMEOUT_CYC = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic [1:0]  contadorTurno,
    output logic [17:0] board,
    output logic [1:0]  winner
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [9:0] PX0 = 10'(ORIGIN_X);
    localparam logic [9:0] PX1 = 10'(ORIGIN_X + CELL_W);
    localparam logic [9:0] PX2 = 10'(ORIGIN_X + 2 * CELL_W);
    localparam logic [9:0] PY0 = 10'(ORIGIN_Y);
    localparam logic [9:0] PY1 = 10'(ORIGIN_Y + CELL_H);
    localparam logic [9:0] PY2 = 10'(ORIGIN_Y + 2 * CELL_H);

    // Eight winning lines, three 4-bit cell indices each; entry i sits at [12*i +: 12]
    localparam logic [95:0] LINE_TBL = {
        4'd2, 4'd4, 4'd6,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd5, 4'd8,
        4'd1, 4'd4, 4'd7,
        4'd0, 4'd3, 4'd6,
        4'd6, 4'd7, 4'd8,
        4'd3, 4'd4, 4'd5,
        4'd0, 4'd1, 4'd2
    };

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 place
    logic [4:0] btn_raw;
    logic [4:0] evt;

    assign btn_raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic sync3_reg;
            logic edge_reg;

            // Two-flop synchroniser, one delay stage and a registered rising-edge pulse
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    sync3_reg <= 1'b0;
                    edge_reg  <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    sync3_reg <= sync2_reg;
                    edge_reg  <= sync2_reg & ~sync3_reg;
                end
            end

            assign evt[gi] = edge_reg;
        end
    endgenerate

    logic ev_up, ev_down, ev_left, ev_right, ev_place;
    assign ev_up    = evt[0];
    assign ev_down  = evt[1];
    assign ev_left  = evt[2];
    assign ev_right = evt[3];
    assign ev_place = evt[4];

    state_t           state_reg;
    logic [17:0]      board_reg;
    logic [1:0]       row_reg;
    logic [1:0]       col_reg;
    logic [1:0]       turn_reg;
    logic [1:0]       winner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [9:0]       posx_reg;
    logic [9:0]       posy_reg;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

    // Cursor cell index row*3+col and its current contents
    logic [3:0] cur_idx;
    logic [1:0] cur_cell;
    logic       placing;
    logic       timeout_hit;
    logic [1:0] cur_mark;

    assign cur_idx     = ({2'b00, row_reg} << 1) + {2'b00, row_reg} + {2'b00, col_reg};
    assign cur_cell    = cell_at(board_reg, cur_idx);
    assign placing     = ev_place && (cur_cell == 2'b00);
    assign timeout_hit = (cnt_reg == CNT_MAX);
    assign cur_mark    = turn_reg[0] ? 2'b10 : 2'b01;

    logic [1:0] win_mark;
    logic       board_full;
    logic [1:0] ca, cb, cc;

    // Scan all eight lines and the fill state of the current board
    always_comb begin
        win_mark   = 2'b00;
        board_full = 1'b1;
        ca         = 2'b00;
        cb         = 2'b00;
        cc         = 2'b00;
        for (int i = 0; i < 8; i++) begin
            ca = cell_at(board_reg, LINE_TBL[12*i+8 +: 4]);
            cb = cell_at(board_reg, LINE_TBL[12*i+4 +: 4]);
            cc = cell_at(board_reg, LINE_TBL[12*i   +: 4]);
            if ((ca != 2'b00) && (ca == cb) && (cb == cc))
                win_mark = ca;
        end
        for (int k = 0; k < 9; k++) begin
            if (cell_at(board_reg, 4'(k)) == 2'b00)
                board_full = 1'b0;
        end
    end

    // Game FSM: cursor, board, turn, timeout, winner and pixel origin registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_PLAY;
            board_reg  <= '0;
            row_reg    <= 2'd1;
            col_reg    <= 2'd1;
            turn_reg   <= 2'd0;
            winner_reg <= 2'b00;
            cnt_reg    <= '0;
            posx_reg   <= PX1;
            posy_reg   <= PY1;
        end else begin
            // Pixel origin trails the row/col registers by one cycle
            case (col_reg)
                2'd0:    posx_reg <= PX0;
                2'd1:    posx_reg <= PX1;
                default: posx_reg <= PX2;
            endcase
            case (row_reg)
                2'd0:    posy_reg <= PY0;
                2'd1:    posy_reg <= PY1;
                default: posy_reg <= PY2;
            endcase

            case (state_reg)
                ST_PLAY: begin
                    if (placing) begin
                        board_reg[{cur_idx, 1'b0} +: 2] <= cur_mark;
                        cnt_reg   <= '0;
                        state_reg <= ST_CHECK;
                    end else begin
                        // Occupied-cell placements do not count as activity
                        if (timeout_hit) begin
                            cnt_reg  <= '0;
                            turn_reg <= {1'b0, ~turn_reg[0]};
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        // A place event, even when ignored, blocks same-cycle moves
                        if (!ev_place) begin
                            if (ev_up) begin
                                if (row_reg != 2'd0) row_reg <= row_reg - 2'd1;
                            end else if (ev_down) begin
                                if (row_reg != 2'd2) row_reg <= row_reg + 2'd1;
                            end else if (ev_left) begin
                                if (col_reg != 2'd0) col_reg <= col_reg - 2'd1;
                            end else if (ev_right) begin
                                if (col_reg != 2'd2) col_reg <= col_reg + 2'd1;
                            end
                        end
                    end
                end

                ST_CHECK: begin
                    cnt_reg <= '0;
                    if (win_mark != 2'b00) begin
                        winner_reg <= win_mark;
                        turn_reg   <= 2'd2;
                        state_reg  <= ST_OVER;
                    end else if (board_full) begin
                        winner_reg <= 2'b00;
                        turn_reg   <= 2'd2;
                        state_reg  <= ST_OVER;
                    end else begin
                        turn_reg  <= {1'b0, ~turn_reg[0]};
                        state_reg <= ST_PLAY;
                    end
                end

                ST_OVER: begin
                    cnt_reg <= '0;
                    if (ev_place) begin
                        board_reg  <= '0;
                        winner_reg <= 2'b00;
                        row_reg    <= 2'd1;
                        col_reg    <= 2'd1;
                        turn_reg   <= 2'd0;
                        state_reg  <= ST_PLAY;
                    end
                end

                default: state_reg <= ST_PLAY;
            endcase
        end
    end

    assign posX          = posx_reg;
    assign posY          = posy_reg;
    assign contadorTurno = turn_reg;
    assign board         = board_reg;
    assign winner        = winner_reg;

endmodule

// File: tb/tb_turn_cursor_ctrl.sv
// Directed bench for turn_cursor_ctrl: one instance with a short idle timeout
// for forfeit behaviour, one with the default timeout for game play.
module tb_turn_cursor_ctrl;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_PLACE = 4;

    logic clk = 1'b0;
    logic rst, btn_up, btn_down, btn_left, btn_right, btn_place;
    logic rst_t, t_place;

    logic [9:0]  posX, posY, t_posX, t_posY;
    logic [1:0]  turn, winner, t_turn, t_winner;
    logic [17:0] board, t_board;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_r    = 1;
    int cur_c    = 1;

    always #5 clk = ~clk;

    turn_cursor_ctrl dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_place(btn_place),
        .posX(posX), .posY(posY), .contadorTurno(turn),
        .board(board), .winner(winner)
    );

    turn_cursor_ctrl #(.TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst(rst_t),
        .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0),
        .btn_right(1'b0), .btn_place(t_place),
        .posX(t_posX), .posY(t_posY), .contadorTurno(t_turn),
        .board(t_board), .winner(t_winner)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive(input int b, input logic v);
        case (b)
            B_UP:    btn_up    = v;
            B_DOWN:  btn_down  = v;
            B_LEFT:  btn_left  = v;
            B_RIGHT: btn_right = v;
            default: btn_place = v;
        endcase
    endtask

    // Press for 3 cycles, release, and let the event fully settle
    task automatic press(input int b);
        drive(b, 1'b1);
        tick(3);
        drive(b, 1'b0);
        tick(3);
    endtask

    task automatic goto_cell(input int r, input int c);
        while (cur_r > r) begin press(B_UP);    cur_r--; end
        while (cur_r < r) begin press(B_DOWN);  cur_r++; end
        while (cur_c > c) begin press(B_LEFT);  cur_c--; end
        while (cur_c < c) begin press(B_RIGHT); cur_c++; end
    endtask

    task automatic place_at(input int r, input int c);
        goto_cell(r, c);
        press(B_PLACE);
    endtask

    initial begin
        rst = 1'b0; rst_t = 1'b0; t_place = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
        btn_right = 1'b0; btn_place = 1'b0;
        tick(2);

        // Idle forfeit with TIMEOUT_CYC=16
        rst_t = 1'b1;
        chk("t_reset_turn", 32'(t_turn), 0);
        tick(15);
        chk("t_idle15_turn", 32'(t_turn), 0);
        tick(1);
        chk("t_timeout_turn", 32'(t_turn), 1);
        chk("t_timeout_board", 32'(t_board), 0);
        tick(15);
        chk("t_single_toggle", 32'(t_turn), 1);

        // Occupied placement must not restart the idle counter
        rst_t = 1'b0;
        tick(1);
        rst_t = 1'b1;
        t_place = 1'b1;
        tick(3);
        t_place = 1'b0;
        tick(1);
        chk("t_place_board", 32'(t_board), 32'h100);
        tick(1);
        chk("t_place_turn", 32'(t_turn), 1);
        t_place = 1'b1;
        tick(3);
        t_place = 1'b0;
        tick(1);
        chk("t_occ_board", 32'(t_board), 32'h100);
        chk("t_occ_turn", 32'(t_turn), 1);
        tick(11);
        chk("t_occ_pre_timeout", 32'(t_turn), 1);
        tick(1);
        chk("t_occ_timeout", 32'(t_turn), 0);

        // Reset values of the main instance
        rst = 1'b1;
        chk("rst_posX", 32'(posX), 240);
        chk("rst_posY", 32'(posY), 160);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_board", 32'(board), 0);
        chk("rst_winner", 32'(winner), 0);

        // Cursor saturation
        press(B_RIGHT);
        press(B_RIGHT);
        chk("sat_right_posX", 32'(posX), 400);
        press(B_DOWN);
        chk("down_posY", 32'(posY), 320);
        press(B_RIGHT);
        chk("sat_right3_posX", 32'(posX), 400);
        press(B_DOWN);
        chk("sat_down_posY", 32'(posY), 320);

        // Asynchronous reset returns the cursor to centre at once
        rst = 1'b0;
        #2;
        chk("async_rst_posX", 32'(posX), 240);
        rst = 1'b1;
        tick(1);
        cur_r = 1; cur_c = 1;

        // X wins on the top row
        place_at(0, 0);
        chk("x00_board", 32'(board), 32'h001);
        chk("x00_turn", 32'(turn), 1);
        press(B_PLACE);
        chk("occ_board", 32'(board), 32'h001);
        chk("occ_turn", 32'(turn), 1);
        place_at(1, 0);
        chk("o10_board", 32'(board), 32'h081);
        chk("o10_turn", 32'(turn), 0);
        place_at(0, 1);
        chk("x01_board", 32'(board), 32'h085);
        place_at(1, 1);
        chk("o11_board", 32'(board), 32'h285);
        chk("o11_turn", 32'(turn), 0);
        goto_cell(0, 2);
        drive(B_PLACE, 1'b1);
        tick(3);
        drive(B_PLACE, 1'b0);
        chk("win_evt_board", 32'(board), 32'h285);
        tick(1);
        chk("win_n1_board", 32'(board), 32'h295);
        chk("win_n1_turn", 32'(turn), 0);
        tick(1);
        chk("win_n2_turn", 32'(turn), 2);
        chk("win_n2_winner", 32'(winner), 1);
        tick(2);
        press(B_LEFT);
        chk("over_move_posX", 32'(posX), 400);
        press(B_PLACE);
        chk("restart_board", 32'(board), 0);
        chk("restart_turn", 32'(turn), 0);
        chk("restart_winner", 32'(winner), 0);
        chk("restart_posX", 32'(posX), 240);
        chk("restart_posY", 32'(posY), 160);
        cur_r = 1; cur_c = 1;

        // Draw: X O X / X O O / O X X
        place_at(0, 0);
        place_at(1, 1);
        place_at(0, 2);
        place_at(0, 1);
        place_at(2, 1);
        place_at(1, 2);
        place_at(1, 0);
        place_at(2, 0);
        chk("draw8_turn", 32'(turn), 0);
        place_at(2, 2);
        chk("draw_board", 32'(board), 32'h16A59);
        chk("draw_winner", 32'(winner), 0);
        chk("draw_turn", 32'(turn), 2);
        press(B_PLACE);
        chk("draw_rs_board", 32'(board), 0);
        chk("draw_rs_turn", 32'(turn), 0);
        chk("draw_rs_posX", 32'(posX), 240);
        chk("draw_rs_posY", 32'(posY), 160);
        cur_r = 1; cur_c = 1;

        // Reset asserted while the FSM is in CHECK
        goto_cell(0, 0);
        drive(B_PLACE, 1'b1);
        tick(3);
        drive(B_PLACE, 1'b0);
        tick(1);
        chk("check_board", 32'(board), 32'h001);
        rst = 1'b0;
        #1;
        chk("chk_rst_board", 32'(board), 0);
        chk("chk_rst_posX", 32'(posX), 240);
        chk("chk_rst_posY", 32'(posY), 160);
        chk("chk_rst_turn", 32'(turn), 0);
        rst = 1'b1;
        tick(1);
        cur_r = 1; cur_c = 1;

        // Left and place in the same cycle: place wins, cursor stays
        btn_left = 1'b1;
        btn_place = 1'b1;
        tick(3);
        btn_left = 1'b0;
        btn_place = 1'b0;
        tick(3);
        chk("pri_posX", 32'(posX), 240);
        chk("pri_board", 32'(board), 32'h100);
        chk("pri_turn", 32'(turn), 1);
        press(B_LEFT);
        chk("after_pri_left", 32'(posX), 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
